// File: rtl/ramio_arbiter_if.sv
// RAMIO request/response bundle: one instance per master port plus one for the shared RAMIO side.
interface ramio_arbiter_if;
  logic        enable;
  logic [1:0]  write_type;
  logic [2:0]  read_type;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;

  modport master (output enable, write_type, read_type, address, data_in,
                  input  data_out, data_out_ready, busy);
  modport slave  (input  enable, write_type, read_type, address, data_in,
                  output data_out, data_out_ready, busy);
endinterface

// File: rtl/ramio_arbiter.sv
// Two-master arbiter for a single RAMIO port: round-robin on contention, per-grant quota,
// one dead cycle on every hand-over, zero-latency pass-through while owned.
module ramio_arbiter #(
  parameter int QUOTA = 8
) (
  input  logic clk,
  input  logic rst_n,
  ramio_arbiter_if.slave  m0,
  ramio_arbiter_if.slave  m1,
  ramio_arbiter_if.master s
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, SWITCH} state_t;
  typedef struct packed {
    logic        en;
    logic [1:0]  wt;
    logic [2:0]  rt;
    logic [31:0] addr;
    logic [31:0] din;
  } req_t;

  localparam logic [8:0] QMAX = 9'(QUOTA);

  state_t     state, state_nxt;
  logic       rr, owner, wr_armed;
  logic [7:0] cnt;
  req_t       req0, req1, sreq;
  logic       own, own_en, other_en, comp, quota_hit;

  assign req0 = m0.enable ? {m0.enable, m0.write_type, m0.read_type, m0.address, m0.data_in} : '0;
  assign req1 = m1.enable ? {m1.enable, m1.write_type, m1.read_type, m1.address, m1.data_in} : '0;

  always_comb begin
    own       = (state == OWN0) || (state == OWN1);
    own_en    = owner ? m1.enable : m0.enable;
    other_en  = owner ? m0.enable : m1.enable;
    sreq      = '0;
    if (own) sreq = owner ? req1 : req0;
    // A write only completes once busy has been seen past its first cycle.
    comp      = own && ((s.data_out_ready && sreq.rt != 3'b000) ||
                        (!s.busy && sreq.wt != 2'b00 && wr_armed));
    quota_hit = ({1'b0, cnt} + 9'd1) >= QMAX;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0.enable && m1.enable) state_nxt = rr ? OWN1 : OWN0;
        else if (m0.enable)         state_nxt = OWN0;
        else if (m1.enable)         state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_en)                            state_nxt = other_en ? SWITCH : IDLE;
        else if (comp && quota_hit && other_en) state_nxt = SWITCH;
      end
      SWITCH: begin
        if (other_en)    state_nxt = owner ? OWN0 : OWN1;
        else if (own_en) state_nxt = owner ? OWN1 : OWN0;
        else             state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= 1'b1;
      owner    <= 1'b0;
      cnt      <= '0;
      wr_armed <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt      <= '0;
        wr_armed <= 1'b0;
      end else begin
        if (comp && {1'b0, cnt} < QMAX) cnt <= cnt + 8'd1;
        wr_armed <= own && !comp && sreq.wt != 2'b00;
      end
      // rr always points away from the master just granted.
      if ((state_nxt == OWN0 || state_nxt == OWN1) && state_nxt != state) begin
        owner <= (state_nxt == OWN1);
        rr    <= (state_nxt == OWN0);
      end
    end
  end

  assign s.enable     = sreq.en;
  assign s.write_type = sreq.wt;
  assign s.read_type  = sreq.rt;
  assign s.address    = sreq.addr;
  assign s.data_in    = sreq.din;

  assign m0.data_out       = s.data_out;
  assign m1.data_out       = s.data_out;
  assign m0.data_out_ready = (state == OWN0) && s.data_out_ready;
  assign m1.data_out_ready = (state == OWN1) && s.data_out_ready;
  assign m0.busy           = (state == OWN0) ? s.busy : 1'b1;
  assign m1.busy           = (state == OWN1) ? s.busy : 1'b1;
endmodule

// File: tb/tb_ramio_arbiter.sv
// Scenario bench for ramio_arbiter with QUOTA=2; expected data/grant sequences queued up front.
module tb_ramio_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ramio_arbiter_if m0_bus ();
  ramio_arbiter_if m1_bus ();
  ramio_arbiter_if s_bus ();

  ramio_arbiter #(.QUOTA(2)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_bus), .m1(m1_bus), .s(s_bus)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          code_q[$];

  task automatic set_m0(input logic en, input logic [1:0] wt, input logic [2:0] rt,
                        input logic [31:0] a, input logic [31:0] d);
    m0_bus.enable = en; m0_bus.write_type = wt; m0_bus.read_type = rt;
    m0_bus.address = a; m0_bus.data_in = d;
  endtask

  task automatic set_m1(input logic en, input logic [1:0] wt, input logic [2:0] rt,
                        input logic [31:0] a, input logic [31:0] d);
    m1_bus.enable = en; m1_bus.write_type = wt; m1_bus.read_type = rt;
    m1_bus.address = a; m1_bus.data_in = d;
  endtask

  task automatic clear_inputs();
    set_m0(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    set_m1(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    s_bus.data_out = 32'h0; s_bus.data_out_ready = 1'b0; s_bus.busy = 1'b0;
  endtask

  // 0/1 = that master granted, 2 = nobody (idle or switch); valid while s_bus.busy is low.
  function automatic int grant_code();
    if (!m0_bus.busy && m1_bus.busy) return 0;
    if (!m1_bus.busy && m0_bus.busy) return 1;
    if (m0_bus.busy && m1_bus.busy && !s_bus.enable) return 2;
    return 3;
  endfunction

  task automatic test_reset();
    clear_inputs();
    set_m0(1'b1, 2'b11, 3'b000, 32'hA0, 32'h11);
    set_m1(1'b1, 2'b00, 3'b011, 32'hB0, 32'h22);
    s_bus.data_out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (s_bus.enable !== 1'b0) begin failures++; $display("FAIL reset_s_enable got=%0b want=0", s_bus.enable); end
    checks++; if ({s_bus.write_type, s_bus.read_type, s_bus.address, s_bus.data_in} !== 69'h0) begin
      failures++; $display("FAIL reset_s_fields got=%h/%h/%h/%h want=0", s_bus.write_type, s_bus.read_type, s_bus.address, s_bus.data_in); end
    checks++; if ({m1_bus.busy, m0_bus.busy} !== 2'b11) begin failures++; $display("FAIL reset_busy got=%b want=11", {m1_bus.busy, m0_bus.busy}); end
    checks++; if ({m1_bus.data_out_ready, m0_bus.data_out_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b want=00", {m1_bus.data_out_ready, m0_bus.data_out_ready}); end
    clear_inputs();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    logic [31:0] e;
    @(negedge clk);
    set_m0(1'b1, 2'b00, 3'b011, 32'h100, 32'h0);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    checks++; if (s_bus.enable !== 1'b0 || m0_bus.busy !== 1'b1) begin
      failures++; $display("FAIL sr_idle en=%0b busy=%0b want en=0 busy=1", s_bus.enable, m0_bus.busy); end
    @(negedge clk); s_bus.busy = 1'b1; #1;
    checks++; if (s_bus.enable !== 1'b1 || s_bus.address !== 32'h100 || s_bus.read_type !== 3'b011) begin
      failures++; $display("FAIL sr_passthru en=%0b addr=%h rt=%b want 1/100/011", s_bus.enable, s_bus.address, s_bus.read_type); end
    @(negedge clk);
    @(negedge clk);
    s_bus.data_out = 32'hDEADBEEF; s_bus.data_out_ready = 1'b1; s_bus.busy = 1'b0;
    #1;
    checks++;
    if (m0_bus.data_out_ready !== 1'b1) begin failures++; $display("FAIL sr_m0_ready got=%0b want=1", m0_bus.data_out_ready); end
    else if (exp_q.size() == 0) begin failures++; $display("FAIL sr_scoreboard got=ready want=no_response"); end
    else begin
      e = exp_q.pop_front();
      if (m0_bus.data_out !== e) begin failures++; $display("FAIL sr_m0_data got=%h want=%h", m0_bus.data_out, e); end
    end
    checks++; if (m1_bus.data_out_ready !== 1'b0 || m1_bus.busy !== 1'b1) begin
      failures++; $display("FAIL sr_m1_blocked ready=%0b busy=%0b want 0/1", m1_bus.data_out_ready, m1_bus.busy); end
    @(negedge clk); clear_inputs();
    @(negedge clk); #1;
    checks++; if (s_bus.enable !== 1'b0 || m0_bus.busy !== 1'b1) begin
      failures++; $display("FAIL sr_back_idle en=%0b busy=%0b want 0/1", s_bus.enable, m0_bus.busy); end
  endtask

  task automatic test_rr_quota();
    int exp;
    @(negedge clk);
    rst_n = 1'b0;
    set_m0(1'b1, 2'b00, 3'b011, 32'h200, 32'h0);
    set_m1(1'b1, 2'b00, 3'b011, 32'h300, 32'h0);
    s_bus.busy = 1'b0; s_bus.data_out_ready = 1'b1; s_bus.data_out = 32'h5A5A0000;
    code_q = {1, 1, 2, 0, 0, 2, 1};
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (grant_code() !== 2) begin failures++; $display("FAIL rr_start_idle got=%0d want=2", grant_code()); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      exp = code_q.pop_front();
      checks++; if (grant_code() !== exp) begin failures++; $display("FAIL rr_grant[%0d] got=%0d want=%0d", i, grant_code(), exp); end
      if (exp != 2) begin
        checks++; if (s_bus.address !== (exp == 1 ? 32'h300 : 32'h200)) begin
          failures++; $display("FAIL rr_addr[%0d] got=%h want=%h", i, s_bus.address, (exp == 1 ? 32'h300 : 32'h200)); end
      end
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_write_busy();
    logic [31:0] e;
    @(negedge clk);
    set_m1(1'b1, 2'b00, 3'b011, 32'h3C, 32'h0);
    @(negedge clk);
    s_bus.data_out = 32'hCAFE0001; s_bus.data_out_ready = 1'b1;
    exp_q.push_back(32'hCAFE0001);
    #1;
    checks++;
    if (m1_bus.data_out_ready !== 1'b1) begin failures++; $display("FAIL wb_m1_ready got=%0b want=1", m1_bus.data_out_ready); end
    else if (exp_q.size() == 0) begin failures++; $display("FAIL wb_scoreboard got=ready want=no_response"); end
    else begin
      e = exp_q.pop_front();
      if (m1_bus.data_out !== e) begin failures++; $display("FAIL wb_m1_data got=%h want=%h", m1_bus.data_out, e); end
    end
    checks++; if (m0_bus.data_out_ready !== 1'b0) begin failures++; $display("FAIL wb_m0_ready got=%0b want=0", m0_bus.data_out_ready); end
    // First write cycle with busy low must not count as a completion.
    @(negedge clk);
    s_bus.data_out_ready = 1'b0; s_bus.busy = 1'b0;
    set_m1(1'b1, 2'b11, 3'b000, 32'h40, 32'h12345678);
    set_m0(1'b1, 2'b00, 3'b011, 32'h500, 32'h0);
    #1;
    checks++; if (s_bus.address !== 32'h40 || s_bus.data_in !== 32'h12345678 || s_bus.write_type !== 2'b11) begin
      failures++; $display("FAIL wb_write_fields addr=%h data=%h wt=%b want 40/12345678/11", s_bus.address, s_bus.data_in, s_bus.write_type); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); s_bus.busy = 1'b1; #1;
      checks++; if (s_bus.address !== 32'h40 || m0_bus.busy !== 1'b1) begin
        failures++; $display("FAIL wb_hold[%0d] addr=%h m0_busy=%0b want 40/1", i, s_bus.address, m0_bus.busy); end
    end
    @(negedge clk); s_bus.busy = 1'b0; #1;
    checks++; if (m1_bus.busy !== 1'b0 || s_bus.address !== 32'h40) begin
      failures++; $display("FAIL wb_complete m1_busy=%0b addr=%h want 0/40", m1_bus.busy, s_bus.address); end
    @(negedge clk);
    set_m1(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    #1;
    checks++; if (s_bus.enable !== 1'b0 || {m1_bus.busy, m0_bus.busy} !== 2'b11) begin
      failures++; $display("FAIL wb_switch en=%0b busy=%b want 0/11", s_bus.enable, {m1_bus.busy, m0_bus.busy}); end
    @(negedge clk); #1;
    checks++; if (s_bus.enable !== 1'b1 || s_bus.address !== 32'h500 || m0_bus.busy !== 1'b0) begin
      failures++; $display("FAIL wb_own0 en=%0b addr=%h m0_busy=%0b want 1/500/0", s_bus.enable, s_bus.address, m0_bus.busy); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_drop_switch();
    @(negedge clk);
    set_m0(1'b1, 2'b00, 3'b011, 32'h600, 32'h0);
    s_bus.busy = 1'b1;
    @(negedge clk);
    set_m1(1'b1, 2'b00, 3'b011, 32'h700, 32'h0);
    #1;
    checks++; if (s_bus.address !== 32'h600 || s_bus.enable !== 1'b1) begin
      failures++; $display("FAIL ds_own0 addr=%h en=%0b want 600/1", s_bus.address, s_bus.enable); end
    @(negedge clk);
    set_m0(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    #1;
    checks++; if (s_bus.enable !== 1'b0) begin failures++; $display("FAIL ds_gated en=%0b want 0", s_bus.enable); end
    @(negedge clk); s_bus.busy = 1'b0; #1;
    checks++; if (s_bus.enable !== 1'b0 || {m1_bus.busy, m0_bus.busy} !== 2'b11) begin
      failures++; $display("FAIL ds_switch en=%0b busy=%b want 0/11", s_bus.enable, {m1_bus.busy, m0_bus.busy}); end
    @(negedge clk); #1;
    checks++; if (s_bus.enable !== 1'b1 || s_bus.address !== 32'h700 || m1_bus.busy !== 1'b0) begin
      failures++; $display("FAIL ds_own1 en=%0b addr=%h m1_busy=%0b want 1/700/0", s_bus.enable, s_bus.address, m1_bus.busy); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_m0(1'b1, 2'b00, 3'b011, 32'h800, 32'h0);
    s_bus.busy = 1'b1;
    @(negedge clk); #1;
    checks++; if (s_bus.address !== 32'h800) begin failures++; $display("FAIL rm_own0 addr=%h want=800", s_bus.address); end
    #2;
    rst_n = 1'b0; s_bus.data_out_ready = 1'b1;
    #1;
    checks++; if (s_bus.enable !== 1'b0 || s_bus.address !== 32'h0) begin
      failures++; $display("FAIL rm_async en=%0b addr=%h want 0/0", s_bus.enable, s_bus.address); end
    checks++; if ({m1_bus.busy, m0_bus.busy} !== 2'b11 || m0_bus.data_out_ready !== 1'b0) begin
      failures++; $display("FAIL rm_async_resp busy=%b m0_ready=%0b want 11/0", {m1_bus.busy, m0_bus.busy}, m0_bus.data_out_ready); end
    @(negedge clk);
    rst_n = 1'b1; s_bus.data_out_ready = 1'b0; s_bus.busy = 1'b0;
    #1;
    checks++; if (s_bus.enable !== 1'b0) begin failures++; $display("FAIL rm_idle en=%0b want 0", s_bus.enable); end
    @(negedge clk); #1;
    checks++; if (s_bus.enable !== 1'b1 || s_bus.address !== 32'h800 || m0_bus.busy !== 1'b0) begin
      failures++; $display("FAIL rm_regrant en=%0b addr=%h m0_busy=%0b want 1/800/0", s_bus.enable, s_bus.address, m0_bus.busy); end
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_rr_quota();
    test_write_busy();
    test_drop_switch();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1);
  end
endmodule

// File: doc/ramio_arbiter.md
RAMIO_ARBITER -- requirements
Module: ramio_arbiter

Interface
REQ-001 Param Quota, default 8: completed transactions a master may perform per grant while the other master is requesting; legal range 1..255.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 mX_enable  in  1  request from master X (X=0 core, X=1 loader/DMA); held high while it wants RAMIO.
REQ-005 mX_write_type  in  2  00 none, 01 byte, 10 half word, 11 word.
REQ-006 mX_read_type  in  3  000 none; bit2 sign-extend; [1:0] 01 byte, 10 half word, 11 word.
REQ-007 mX_address  in  32  byte address.
REQ-008 mX_data_in  in  32  write data.
REQ-009 mX_data_out  out  32  copy of s_data_out, driven to both masters.
REQ-010 mX_data_out_ready  out  1  s_data_out_ready when X is granted, else 0.
REQ-011 mX_busy  out  1  s_busy when X is granted, else 1.
REQ-012 s_enable, s_write_type, s_read_type, s_address, s_data_in  out  1/2/3/32/32  shared RAMIO request.
REQ-013 s_data_out  in  32;  s_data_out_ready  in  1;  s_busy  in  1  shared RAMIO response.

Function
REQ-014 FSM states: Idle, Own0, Own1, Switch; exactly one state active.
REQ-015 Idle: s_enable=0, all s_* request fields 0; mX_busy=1 and mX_data_out_ready=0 for both masters.
REQ-016 Idle, exactly one mX_enable high -> OwnX on next edge.
REQ-017 Idle, both high -> Own of the master indicated by rr pointer; rr resets to 1 and after each grant points to the other master.
REQ-018 OwnX: s_* combinationally equal the mX_* request fields, gated by mX_enable; zero-cycle latency in both directions.
REQ-019 Completion event in OwnX: s_data_out_ready=1 with s_read_type!=0, or s_busy=0 with s_write_type!=0 on any cycle after the first cycle of that write (wr_armed flag, cleared on completion and on grant change).
REQ-020 8-bit counter cnt clears on entry to OwnX and increments on each completion event, saturating at Quota.
REQ-021 OwnX -> Switch when the other master requests and either mX_enable=0 or (cnt reaches Quota on a completion event); Switch is evaluated only on completion cycles or idle-enable cycles, never mid-transaction.
REQ-022 OwnX -> Idle when mX_enable=0 and the other master is not requesting.
REQ-023 Switch lasts exactly one cycle: s_enable=0, both mX_busy=1. It then enters Own of the other master if that master still requests, else Own of the previous master if it still requests, else Idle.
REQ-024 The completing cycle's s_data_out_ready/s_busy reaches the old owner before any state change; no response is ever routed to a non-owner.
REQ-025 A non-granted master that holds enable stalls indefinitely with busy=1 and ready=0; no request is dropped or reordered.
REQ-026 Both masters dropping enable in the same cycle as a completion -> Idle.

Reset
REQ-027 rst_n low at any time, including mid-transaction: immediately state=Idle, rr=1, cnt=0, wr_armed=0, s_enable=0, all s_* request fields 0, mX_busy=1, mX_data_out_ready=0; no pending transaction is resumed.

Verification
REQ-028 Only m0 requests a word read at 0x100; slave returns 0xDEADBEEF with ready two cycles later -> m0 receives 0xDEADBEEF with ready=1; m1 sees ready=0, busy=1.
REQ-029 Both masters request from Idle just after reset -> m1 is granted first; with Quota=2 and both continuously requesting, the sequence is m1, m1, Switch, m0, m0, Switch, m1.
REQ-030 m1 issues an SW of 0x12345678 at 0x40 and the slave holds busy for 3 cycles while m0 requests -> no switch until the busy=0 cycle; then Switch for 1 cycle, then s_address follows m0.
REQ-031 m0 owns the bus, drops enable while m1 requests -> exactly one Switch cycle with s_enable=0, then Own1.
REQ-032 rst_n asserted during an Own0 read -> on the same cycle s_enable=0 and both busy=1; after release, a single m0 request is granted one cycle later.
